// File: rtl/lj_pair_scheduler_pkg.sv
// Shared types and constants for the Lennard-Jones pair scheduler.
package lj_sched_pkg;

  localparam int          LJ_CORE_LAT = 7;
  localparam int          TAG_ID_W    = 3;
  localparam logic [31:0] ONE         = 32'h0001_0000;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                zero;
  } tag_t;

  // Non-positive or below-cutoff 1/r^2 skips the math; signed Q16.16 compare.
  function automatic logic is_bypass(input logic [31:0] r2_inv, input logic [31:0] cut);
    return ($signed(r2_inv) <= 32'sd0) || ($signed(r2_inv) < $signed(cut));
  endfunction

endpackage

// File: rtl/lj_pair_scheduler_if.sv
// Requester-side bus of the pair scheduler: packed pair requests in, tagged results out.
interface lj_pair_scheduler_if #(
  parameter int NREQ   = 4,
  parameter int TYPE_W = 2
);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*32-1:0]      req_r2_inv;
  logic [NREQ*TYPE_W-1:0]  req_type;
  logic                    rsp_valid;
  logic [$clog2(NREQ)-1:0] rsp_id;
  logic [31:0]             rsp_f_lj;

  modport master (
    output req_valid, req_r2_inv, req_type,
    input  req_ready, rsp_valid, rsp_id, rsp_f_lj
  );

  modport slave (
    input  req_valid, req_r2_inv, req_type,
    output req_ready, rsp_valid, rsp_id, rsp_f_lj
  );

endinterface

// File: rtl/lj_pair_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the winner.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         i_valid,
  output logic [NREQ-1:0]         o_grant,
  output logic [$clog2(NREQ)-1:0] o_gnt_id,
  output logic                    o_gnt_valid
);

  localparam int             IDW  = $clog2(NREQ);
  localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_ptr_nxt;
  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_idx;

  // Scan requesters upward from the pointer with wrap; first valid wins.
  always_comb begin
    o_grant     = '0;
    o_gnt_id    = '0;
    o_gnt_valid = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NREQ)) begin
        w_sum = w_sum - (IDW+1)'(NREQ);
      end else begin
        w_sum = w_sum;
      end
      w_idx = w_sum[IDW-1:0];
      if (!o_gnt_valid && i_valid[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_gnt_id       = w_idx;
        o_gnt_valid    = 1'b1;
      end else begin
        o_gnt_valid = o_gnt_valid;
      end
    end
  end

  // Next pointer: one past the winner, or unchanged when idle.
  always_comb begin
    if (!o_gnt_valid) begin
      w_ptr_nxt = r_ptr;
    end else if (o_gnt_id == LAST) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = o_gnt_id + IDW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/lj_pair_scheduler.sv
// Shares one fixed-latency Lennard-Jones core between NREQ requesters; each pair
// carries a tag through the core so its result returns with the requester id.
module lj_pair_scheduler
  import lj_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int TYPE_W = 2,
  parameter int LAT    = LJ_CORE_LAT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [TYPE_W-1:0]        cfg_type,
  input  logic [31:0]              cfg_sigma_sq,
  input  logic [31:0]              cfg_eps_x24,
  input  logic                     cfg_cut_we,
  input  logic [31:0]              cfg_r2_inv_cut,
  lj_pair_scheduler_if.slave       req_if,
  output logic [31:0]              core_sigma_sq,
  output logic [31:0]              core_epsilon_x24,
  output logic [31:0]              core_r2_inv,
  input  logic [31:0]              core_f_lj,
  output logic [$clog2(LAT+2)-1:0] inflight,
  output logic [31:0]              pair_count
);

  localparam int IDW   = $clog2(NREQ);
  localparam int CNT_W = $clog2(LAT + 2);
  localparam int DEPTH = 2 ** TYPE_W;

  logic [NREQ-1:0]   w_grant;
  logic [IDW-1:0]    w_gnt_id;
  logic              w_gnt_valid;
  logic [31:0]       w_r2   [NREQ];
  logic [TYPE_W-1:0] w_type [NREQ];
  logic [31:0]       w_sel_r2;
  logic [TYPE_W-1:0] w_sel_type;
  logic              w_zero;
  logic [31:0]       r_sigma [DEPTH];
  logic [31:0]       r_eps   [DEPTH];
  logic [31:0]       r_cut;
  tag_t              r_tags  [LAT+1];
  tag_t              w_push;
  tag_t              w_out;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (req_if.req_valid),
    .o_grant     (w_grant),
    .o_gnt_id    (w_gnt_id),
    .o_gnt_valid (w_gnt_valid)
  );

  assign req_if.req_ready = w_grant;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_r2[g]   = req_if.req_r2_inv[32*g +: 32];
    assign w_type[g] = req_if.req_type[TYPE_W*g +: TYPE_W];
  end

  assign w_sel_r2   = w_r2[w_gnt_id];
  assign w_sel_type = w_type[w_gnt_id];
  assign w_zero     = is_bypass(w_sel_r2, r_cut);
  assign w_out      = r_tags[LAT];

  // Tag entering the pipe this cycle; an idle slot pushes an invalid tag.
  always_comb begin
    w_push = '0;
    if (w_gnt_valid) begin
      w_push.valid = 1'b1;
      w_push.id    = TAG_ID_W'(w_gnt_id);
      w_push.zero  = w_zero;
    end else begin
      w_push.valid = 1'b0;
    end
  end

  // Host-programmed parameter table and cutoff; reads this edge see old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < DEPTH; t++) begin
        r_sigma[t] <= 32'd0;
        r_eps[t]   <= 32'd0;
      end
      r_cut <= 32'd0;
    end else begin
      if (cfg_we) begin
        r_sigma[cfg_type] <= cfg_sigma_sq;
        r_eps[cfg_type]   <= cfg_eps_x24;
      end
      if (cfg_cut_we) begin
        r_cut <= cfg_r2_inv_cut;
      end
    end
  end

  // Core operand registers; bypassed pairs drive zeros to keep the core quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_r2_inv      <= 32'd0;
      core_sigma_sq    <= 32'd0;
      core_epsilon_x24 <= 32'd0;
    end else if (w_gnt_valid) begin
      core_r2_inv      <= w_zero ? 32'd0 : w_sel_r2;
      core_sigma_sq    <= w_zero ? 32'd0 : r_sigma[w_sel_type];
      core_epsilon_x24 <= w_zero ? 32'd0 : r_eps[w_sel_type];
    end
  end

  // Tag pipe tracking pairs through the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j <= LAT; j++) begin
        r_tags[j] <= '0;
      end
    end else begin
      r_tags[0] <= w_push;
      for (int j = 1; j <= LAT; j++) begin
        r_tags[j] <= r_tags[j-1];
      end
    end
  end

  // Occupancy and accepted-pair counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight   <= '0;
      pair_count <= 32'd0;
    end else begin
      case ({w_push.valid, w_out.valid})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
      if (w_gnt_valid) begin
        pair_count <= pair_count + 32'd1;
      end
    end
  end

  // Result routing, aligned with the core output.
  always_comb begin
    req_if.rsp_valid = w_out.valid;
    if (w_out.valid) begin
      req_if.rsp_id   = IDW'(w_out.id);
      req_if.rsp_f_lj = w_out.zero ? 32'd0 : core_f_lj;
    end else begin
      req_if.rsp_id   = '0;
      req_if.rsp_f_lj = 32'd0;
    end
  end

endmodule

// File: tb/tb_lj_pair_scheduler.sv
// Directed bench for lj_pair_scheduler with a behavioural 7-stage core and a
// scoreboard of expected results checked against rsp_* as they emerge.
module tb_lj_pair_scheduler;
  import lj_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int TYPE_W = 2;
  localparam int LAT = 7;

  typedef struct {
    int          id;
    logic [31:0] f;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we, cfg_cut_we;
  logic [1:0]  cfg_type;
  logic [31:0] cfg_sigma_sq, cfg_eps_x24, cfg_r2_inv_cut;
  logic [31:0] core_sigma_sq, core_epsilon_x24, core_r2_inv, core_f_lj;
  logic [3:0]  inflight;
  logic [31:0] pair_count;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  exp_t        sb[$];
  int          iss[$];
  logic [31:0] got_f[$];
  int          got_id[$];
  logic [31:0] m_sig[4], m_eps[4];
  logic [31:0] m_cut, m_cr2, m_csig, m_ceps, m_pairs;
  int          m_ptr;
  logic [31:0] core_pipe[LAT];

  lj_pair_scheduler_if #(.NREQ(NREQ), .TYPE_W(TYPE_W)) bus ();

  lj_pair_scheduler #(.NREQ(NREQ), .TYPE_W(TYPE_W), .LAT(LAT)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_we           (cfg_we),
    .cfg_type         (cfg_type),
    .cfg_sigma_sq     (cfg_sigma_sq),
    .cfg_eps_x24      (cfg_eps_x24),
    .cfg_cut_we       (cfg_cut_we),
    .cfg_r2_inv_cut   (cfg_r2_inv_cut),
    .req_if           (bus),
    .core_sigma_sq    (core_sigma_sq),
    .core_epsilon_x24 (core_epsilon_x24),
    .core_r2_inv      (core_r2_inv),
    .core_f_lj        (core_f_lj),
    .inflight         (inflight),
    .pair_count       (pair_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] q_mul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return p[47:16];
  endfunction

  function automatic logic [31:0] lj_force(input logic [31:0] sig, input logic [31:0] eps,
                                           input logic [31:0] r2);
    logic [31:0] s, s3, s6, t;
    s  = q_mul(sig, r2);
    s3 = q_mul(q_mul(s, s), s);
    s6 = q_mul(s3, s3);
    t  = (s6 << 1) - s3;
    return q_mul(q_mul(eps, t), r2);
  endfunction

  // Behavioural core: result appears LAT clocks after the operands are sampled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < LAT; j++) core_pipe[j] <= 32'd0;
    end else begin
      core_pipe[0] <= lj_force(core_sigma_sq, core_epsilon_x24, core_r2_inv);
      for (int j = 1; j < LAT; j++) core_pipe[j] <= core_pipe[j-1];
    end
  end
  assign core_f_lj = core_pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every rsp_valid.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 32'(bus.rsp_id), e.id);
          chk("rsp_f_lj", bus.rsp_f_lj, e.f);
          chk("rsp_latency", cyc, e.due);
          got_f.push_back(bus.rsp_f_lj);
          got_id.push_back(int'(bus.rsp_id));
        end
      end else begin
        chk("idle_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("idle_rsp_f", bus.rsp_f_lj, 32'd0);
      end
    end
  end

  task automatic model_reset();
    for (int t = 0; t < 4; t++) begin
      m_sig[t] = 32'd0;
      m_eps[t] = 32'd0;
    end
    m_cut = 32'd0; m_cr2 = 32'd0; m_csig = 32'd0; m_ceps = 32'd0;
    m_pairs = 32'd0; m_ptr = 0;
    sb.delete(); iss.delete();
  endtask

  task automatic set_req(input int i, input logic [31:0] r2, input logic [1:0] ty);
    bus.req_valid[i] = 1'b1;
    bus.req_r2_inv[32*i +: 32] = r2;
    bus.req_type[2*i +: 2] = ty;
  endtask

  task automatic clear_req();
    bus.req_valid = '0;
  endtask

  // One clock: check registered state and the grant, update the model, advance.
  task automatic step();
    int g, cnt, idx;
    logic [31:0] r2;
    logic [1:0] ty;
    logic z;
    exp_t e;
    #1;
    cnt = 0;
    foreach (iss[j]) if (iss[j] >= cyc - 8) cnt++;
    chk("inflight", 32'(inflight), cnt);
    chk("pair_count", pair_count, m_pairs);
    chk("core_r2_inv", core_r2_inv, m_cr2);
    chk("core_sigma_sq", core_sigma_sq, m_csig);
    chk("core_eps_x24", core_epsilon_x24, m_ceps);
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (g < 0 && bus.req_valid[idx]) g = idx;
    end
    chk("req_ready", 32'(bus.req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    if (g >= 0) begin
      r2 = bus.req_r2_inv[32*g +: 32];
      ty = bus.req_type[2*g +: 2];
      z = ($signed(r2) <= 32'sd0) || ($signed(r2) < $signed(m_cut));
      m_cr2  = z ? 32'd0 : r2;
      m_csig = z ? 32'd0 : m_sig[ty];
      m_ceps = z ? 32'd0 : m_eps[ty];
      e.id = g;
      e.f = z ? 32'd0 : lj_force(m_sig[ty], m_eps[ty], r2);
      e.due = cyc + LAT + 1;
      sb.push_back(e);
      iss.push_back(cyc);
      m_pairs = m_pairs + 32'd1;
      m_ptr = (g + 1) % NREQ;
    end
    if (cfg_we) begin
      m_sig[cfg_type] = cfg_sigma_sq;
      m_eps[cfg_type] = cfg_eps_x24;
    end
    if (cfg_cut_we) m_cut = cfg_r2_inv_cut;
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
    cfg_cut_we = 1'b0;
  endtask

  task automatic idle(input int n);
    clear_req();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus.req_valid = '0; bus.req_r2_inv = '0; bus.req_type = '0;
    cfg_we = 1'b0; cfg_cut_we = 1'b0; cfg_type = 2'd0;
    cfg_sigma_sq = 32'd0; cfg_eps_x24 = 32'd0; cfg_r2_inv_cut = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_pair_count", pair_count, 32'd0);
    chk("rst_core_r2", core_r2_inv, 32'd0);
    chk("rst_core_sig", core_sigma_sq, 32'd0);
    rst_n = 1'b1;

    // Program table[1] = {1.0, 24.0}; cutoff stays 0.
    cfg_we = 1'b1; cfg_type = 2'd1; cfg_sigma_sq = ONE; cfg_eps_x24 = 32'h0018_0000;
    step();

    // Single pair.
    got_f.delete(); got_id.delete();
    set_req(0, ONE, 2'd1);
    step();
    idle(10);
    chk("single_count", got_f.size(), 32'd1);
    if (got_f.size() == 1) begin
      chk("single_f", got_f[0], 32'h0018_0000);
      chk("single_id", got_id[0], 32'd0);
    end

    // Cutoff bypass: pointer is 1 here, so req2 then req3 win in turn.
    cfg_cut_we = 1'b1; cfg_r2_inv_cut = 32'h0000_4000;
    step();
    got_f.delete(); got_id.delete();
    set_req(2, 32'h0000_2000, 2'd1);
    step();
    chk("cut_core_r2_zero", core_r2_inv, 32'd0);
    clear_req();
    set_req(3, 32'hFFFF_FFFF, 2'd1);
    step();
    chk("cut_core_eps_zero", core_epsilon_x24, 32'd0);
    idle(10);
    chk("cut_count", got_f.size(), 32'd2);
    if (got_f.size() == 2) begin
      chk("cut_f0", got_f[0], 32'd0);
      chk("cut_f1", got_f[1], 32'd0);
      chk("cut_id0", got_id[0], 32'd2);
      chk("cut_id1", got_id[1], 32'd3);
    end

    // Fairness: all four valid for 8 cycles, pointer starts at 0.
    got_f.delete(); got_id.delete();
    set_req(0, 32'h0001_0000, 2'd1);
    set_req(1, 32'h0000_8000, 2'd1);
    set_req(2, 32'h0002_0000, 2'd1);
    set_req(3, 32'h0001_8000, 2'd1);
    for (int i = 0; i < 8; i++) step();
    clear_req();
    #1;
    chk("fair_inflight_peak", 32'(inflight), 32'd8);
    idle(10);
    chk("fair_count", got_id.size(), 32'd8);
    if (got_id.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("fair_order", got_id[i], i % 4);
      chk("fair_f2", got_f[2], 32'h1680_0000);
    end

    // Table write in the same cycle as a type-1 handshake.
    got_f.delete(); got_id.delete();
    set_req(0, ONE, 2'd1);
    cfg_we = 1'b1; cfg_type = 2'd1; cfg_sigma_sq = ONE; cfg_eps_x24 = 32'h0030_0000;
    step();
    step();
    idle(10);
    chk("cfg_count", got_f.size(), 32'd2);
    if (got_f.size() == 2) begin
      chk("cfg_first_old", got_f[0], 32'h0018_0000);
      chk("cfg_second_new", got_f[1], 32'h0030_0000);
    end

    // Sparse: req3 alone wraps the pointer to 0, then req1 alone.
    got_f.delete(); got_id.delete();
    clear_req();
    set_req(3, ONE, 2'd1);
    step();
    clear_req();
    set_req(1, ONE, 2'd1);
    step();
    idle(10);
    chk("sparse_count", got_id.size(), 32'd2);
    if (got_id.size() == 2) begin
      chk("sparse_id0", got_id[0], 32'd3);
      chk("sparse_id1", got_id[1], 32'd1);
    end

    // Reset while five pairs are in flight.
    set_req(0, ONE, 2'd1); set_req(1, ONE, 2'd1);
    set_req(2, ONE, 2'd1); set_req(3, ONE, 2'd1);
    for (int i = 0; i < 5; i++) step();
    idle(2);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_inflight", 32'(inflight), 32'd0);
    chk("mid_rst_pair_count", pair_count, 32'd0);
    idle(12);
    set_req(0, ONE, 2'd1); set_req(1, ONE, 2'd1);
    set_req(2, ONE, 2'd1); set_req(3, ONE, 2'd1);
    step();
    idle(10);

    chk("sb_drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lj_pair_scheduler.md
Name: lj_pair_scheduler

Overview:
- Shares one `lennard_jones_core` instance between NREQ pair-force requesters using round-robin arbitration.
- Holds a per-atom-type parameter table (sigma_sq, epsilon_x24) and a cutoff register, programmed by the host.
- Drives the core one pair per cycle, tracks in-flight tags through the fixed-latency core, and routes each result back with its requester id.
- Pairs outside the cutoff bypass the math (result forced to 0) without breaking result ordering.

Parameters:
- NREQ, 4, number of requesters (2..8)
- TYPE_W, 2, type-index width; table depth 2**TYPE_W
- LAT, 7, core latency in clocks, input sample to f_lj update

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  write table entry cfg_type
- cfg_type  in  TYPE_W  table index
- cfg_sigma_sq  in  32  Q16.16
- cfg_eps_x24  in  32  Q16.16
- cfg_cut_we  in  1  write cutoff register
- cfg_r2_inv_cut  in  32  Q16.16 minimum 1/r^2 to compute
- req_valid  in  NREQ  per-requester valid
- req_ready  out  NREQ  one-hot grant
- req_r2_inv  in  NREQ*32  packed Q16.16, slot i at [32i+31:32i]
- req_type  in  NREQ*TYPE_W  packed pair type
- core_sigma_sq  out  32  to core
- core_epsilon_x24  out  32  to core
- core_r2_inv  out  32  to core
- core_f_lj  in  32  from core
- rsp_valid  out  1  result valid (no backpressure)
- rsp_id  out  $clog2(NREQ)  requester of result
- rsp_f_lj  out  32  Q16.16 force
- inflight  out  $clog2(LAT+2)  pairs in flight
- pair_count  out  32  accepted pairs, wraps

Behaviour:
- Reset values:
  - All outputs 0.
  - Table entries 0; cutoff register 0.
  - RR pointer 0; tag pipe all invalid.
- Arbitration:
  - Scan req_valid starting at the pointer, ascending with wrap; the first set bit is granted.
  - req_ready is combinational and at most one-hot. req_ready[i] can be 1 only when req_valid[i] is 1.
  - On a grant to i, the pointer becomes (i+1) mod NREQ. With no grant, the pointer holds.
  - A request must hold its data while valid and not ready.
- Issue, on the edge of the handshake:
  - Register core_r2_inv = req_r2_inv[i].
  - Register core_sigma_sq and core_epsilon_x24 from the table at req_type[i].
  - Push tag {valid=1, id=i, zero} into stage 0 of an LAT+1-deep tag pipe.
  - zero = (r2_inv <= 0) or (r2_inv < cut_reg), signed compare.
  - If zero, core inputs are registered as 0 to save toggling.
  - With no handshake, push an invalid tag. Core input registers hold their values.
- Latency:
  - A handshake in cycle k gives rsp_valid high in cycle k+LAT+1 (8 by default), aligned with core_f_lj.
  - rsp_f_lj = zero ? 0 : core_f_lj. rsp_id comes from the tag.
  - rsp_id and rsp_f_lj are 0 when rsp_valid is 0.
  - Results emerge in issue order. Throughput is 1 pair per clock.
- Counters:
  - inflight = number of valid tags in the pipe. It increments on issue and decrements on response; simultaneous issue and response leaves it unchanged.
  - pair_count increments per handshake and wraps at 2^32.
- Configuration:
  - A table or cutoff write takes effect for handshakes in later cycles.
  - A handshake in the same cycle as a write uses the old value, even for the same type.
  - A write never disturbs pairs in flight, because parameters travel with the pair.
- Reset mid-operation: all tags are discarded and no stale rsp_valid is produced. The core is reset by the same rst_n.
- Arithmetic: no saturation here; overflow behaviour is the core's.

Decomposition:
- Package `lj_sched_pkg`:
  - tag struct {valid, id, zero}
  - LJ_CORE_LAT = 7
  - Q16.16 constant ONE = 32'h0001_0000
- Sub-module `rr_arbiter` (NREQ): combinational grant plus pointer register.
- Parameter table and tag pipe stay inline.
- The core is instantiated at the top level next to this block, not inside it.

Test Plan:
- Single pair:
  - Stimulus: table[1] = {sigma_sq 0x0001_0000, eps_x24 0x0018_0000}, cutoff 0; req0 r2_inv 0x0001_0000, type 1.
  - Response: rsp_valid exactly 8 cycles after the handshake, rsp_id 0, rsp_f_lj 0x0018_0000 (24.0).
- Fairness:
  - Stimulus: all 4 requesters valid continuously for 8 cycles.
  - Response: grant order 0,1,2,3,0,1,2,3; responses in the same id order, back-to-back; inflight peaks at 8.
- Cutoff bypass:
  - Stimulus: cutoff 0x0000_4000; req2 r2_inv 0x0000_2000, then req3 r2_inv -1.
  - Response: both return rsp_f_lj 0 with ids 2 and 3, in order; core inputs registered as 0 for those cycles.
- Config same cycle:
  - Stimulus: write table[1] eps_x24 = 0x0030_0000 in the same cycle as a type-1 handshake, then a second type-1 pair.
  - Response: first result 0x0018_0000, second 0x0030_0000.
- Reset mid-flight:
  - Stimulus: issue 5 pairs, assert rst_n low for 1 cycle 3 cycles later.
  - Response: no rsp_valid afterwards; inflight 0, pair_count 0, pointer 0.
- Sparse and wrap:
  - Stimulus: only req3 valid, then only req1 valid.
  - Response: pointer wraps to 0, req1 granted next cycle; idle cycles produce no rsp_valid.
